// File: rtl/voq_sched_picker.sv
// Registered VOQ picker for one ingress port: round-robin or priority-list selection
// behind a req/valid/ready handshake, with an anti-starvation skip counter per VOQ.
//
// state    | meaning
// ST_IDLE  | waiting for pick_req; priority table writable; eligibility snapshot taken on pick_req
// ST_CALC  | selection evaluated on the snapshot, result registered
// ST_OFFER | result presented (pick_valid=1) until pick_ready
module voq_sched_picker #(
  parameter int  N_PORTS  = 4,
  parameter int  MAX_SKIP = 8,
  localparam int IDX_W    = $clog2(N_PORTS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     policy,
  input  logic                     prio_wr_en,
  input  logic [N_PORTS*IDX_W-1:0] prio_wr_data,
  input  logic [N_PORTS-1:0]       voq_empty,
  input  logic [N_PORTS-1:0]       voq_picked,
  input  logic                     pick_req,
  output logic                     pick_valid,
  input  logic                     pick_ready,
  output logic [IDX_W-1:0]         voq_to_pick,
  output logic                     no_available_voq
);

  localparam int CNT_W = (MAX_SKIP > 0) ? $clog2(MAX_SKIP + 1) : 1;
  localparam logic [CNT_W-1:0] SKIP_MAX = CNT_W'(MAX_SKIP);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_OFFER} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_PORTS-1:0] r_elig;
  logic               r_policy;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_prio      [N_PORTS];
  logic [IDX_W-1:0]   r_prio_snap [N_PORTS];
  logic [CNT_W-1:0]   r_skip      [N_PORTS];
  logic               r_valid;
  logic               r_none;
  logic [IDX_W-1:0]   r_voq;

  logic [N_PORTS-1:0] w_elig;
  logic               w_hs;
  logic [IDX_W-1:0]   w_scan [N_PORTS];
  logic [IDX_W-1:0]   w_sel;
  logic               w_found;

  assign w_elig = ~voq_empty & ~voq_picked;
  assign w_hs   = (r_state == ST_OFFER) && pick_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (pick_req) w_state_nxt = ST_CALC;
      ST_CALC:  w_state_nxt = ST_OFFER;
      ST_OFFER: if (pick_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < N_PORTS; k++) w_scan[k] = r_rr_ptr + IDX_W'(k);
  end

  // Starvation override first, then RR or table scan; no hit leaves w_sel at rr_ptr.
  always_comb begin
    w_sel   = r_rr_ptr;
    w_found = 1'b0;
    if ((MAX_SKIP > 0) && r_policy) begin
      for (int k = 0; k < N_PORTS; k++) begin
        if (!w_found && r_elig[w_scan[k]] && (r_skip[w_scan[k]] >= SKIP_MAX)) begin
          w_found = 1'b1;
          w_sel   = w_scan[k];
        end
      end
    end
    if (!w_found && !r_policy) begin
      for (int k = 0; k < N_PORTS; k++) begin
        if (!w_found && r_elig[w_scan[k]]) begin
          w_found = 1'b1;
          w_sel   = w_scan[k];
        end
      end
    end
    if (!w_found && r_policy) begin
      for (int k = 0; k < N_PORTS; k++) begin
        if (!w_found && r_elig[r_prio_snap[k]]) begin
          w_found = 1'b1;
          w_sel   = r_prio_snap[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_elig   <= '0;
      r_policy <= 1'b0;
      r_rr_ptr <= '0;
      r_valid  <= 1'b0;
      r_none   <= 1'b0;
      r_voq    <= '0;
      for (int k = 0; k < N_PORTS; k++) begin
        r_prio[k]      <= IDX_W'(k);
        r_prio_snap[k] <= IDX_W'(k);
        r_skip[k]      <= '0;
      end
    end else begin
      // Snapshot copies the table before any same-cycle write lands.
      if ((r_state == ST_IDLE) && pick_req) begin
        r_elig      <= w_elig;
        r_policy    <= policy;
        r_prio_snap <= r_prio;
      end
      if ((r_state == ST_IDLE) && prio_wr_en) begin
        for (int k = 0; k < N_PORTS; k++) r_prio[k] <= prio_wr_data[k*IDX_W +: IDX_W];
      end
      if (r_state == ST_CALC) begin
        r_voq   <= w_sel;
        r_none  <= !w_found;
        r_valid <= 1'b1;
      end
      if (w_hs) begin
        r_valid <= 1'b0;
        if (!r_none) begin
          r_rr_ptr <= r_voq + IDX_W'(1);
          if (r_policy) begin
            for (int i = 0; i < N_PORTS; i++) begin
              if ((IDX_W'(i) == r_voq) || !r_elig[i]) r_skip[i] <= '0;
              else if (r_skip[i] < SKIP_MAX)          r_skip[i] <= r_skip[i] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  assign pick_valid       = r_valid;
  assign voq_to_pick      = r_voq;
  assign no_available_voq = r_none;

endmodule

// File: tb/tb_voq_sched_picker.sv
// Scoreboard bench for voq_sched_picker (N_PORTS=4, MAX_SKIP=2): expected {none,voq}
// is queued when a pick is requested and compared when the handshake happens.
module tb_voq_sched_picker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       policy;
  logic       prio_wr_en;
  logic [7:0] prio_wr_data;
  logic [3:0] voq_empty;
  logic [3:0] voq_picked;
  logic       pick_req;
  logic       pick_valid;
  logic       pick_ready;
  logic [1:0] voq_to_pick;
  logic       no_available_voq;

  int         checks   = 0;
  int         failures = 0;
  logic [2:0] sb_q [$];

  always #5 clk = ~clk;

  voq_sched_picker #(.N_PORTS(4), .MAX_SKIP(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .policy           (policy),
    .prio_wr_en       (prio_wr_en),
    .prio_wr_data     (prio_wr_data),
    .voq_empty        (voq_empty),
    .voq_picked       (voq_picked),
    .pick_req         (pick_req),
    .pick_valid       (pick_valid),
    .pick_ready       (pick_ready),
    .voq_to_pick      (voq_to_pick),
    .no_available_voq (no_available_voq)
  );

  // Scoreboard consumer: every accepted result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && pick_valid && pick_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got none=%0b voq=%0d with nothing expected", no_available_voq, voq_to_pick);
      end else begin
        logic [2:0] exp;
        exp = sb_q.pop_front();
        if ({no_available_voq, voq_to_pick} !== exp) begin
          failures++;
          $display("FAIL sb_pick: got none=%0b voq=%0d, want none=%0b voq=%0d",
                   no_available_voq, voq_to_pick, exp[2], exp[1:0]);
        end
      end
    end
  end

  task automatic drive_defaults();
    policy       = 1'b0;
    prio_wr_en   = 1'b0;
    prio_wr_data = 8'h00;
    voq_empty    = 4'b0000;
    voq_picked   = 4'b0000;
    pick_req     = 1'b0;
    pick_ready   = 1'b1;
  endtask

  task automatic apply_reset();
    drive_defaults();
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_hs();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (pick_valid && pick_ready) break;
      n++;
      if (n > 20) begin
        checks++;
        failures++;
        $display("FAIL hs_timeout: pick_valid=%0b pick_ready=%0b after 20 cycles, want handshake", pick_valid, pick_ready);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_pick(input logic [1:0] voq, input logic none);
    sb_q.push_back({none, voq});
    pick_req = 1'b1;
    @(posedge clk); #1;
    pick_req = 1'b0;
    wait_hs();
  endtask

  task automatic test_reset();
    drive_defaults();
    reset_n = 1'b0;
    #12;
    checks++; if (pick_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b want 0", pick_valid); end
    checks++; if (voq_to_pick !== 2'd0) begin failures++; $display("FAIL rst_voq: got %0d want 0", voq_to_pick); end
    checks++; if (no_available_voq !== 1'b0) begin failures++; $display("FAIL rst_none: got %0b want 0", no_available_voq); end
    apply_reset();
  endtask

  task automatic test_rr();
    apply_reset();
    sb_q.push_back(3'b0_00);
    pick_req = 1'b1;
    @(posedge clk); #1;
    pick_req = 1'b0;
    @(negedge clk);
    checks++; if (pick_valid !== 1'b0) begin failures++; $display("FAIL lat_calc: got valid=%0b want 0", pick_valid); end
    @(negedge clk);
    checks++; if (pick_valid !== 1'b1) begin failures++; $display("FAIL lat_offer: got valid=%0b want 1", pick_valid); end
    @(posedge clk); #1;
    run_pick(2'd1, 1'b0);
    run_pick(2'd2, 1'b0);
    run_pick(2'd3, 1'b0);
    run_pick(2'd0, 1'b0);
  endtask

  task automatic test_rr_wrap();
    apply_reset();
    run_pick(2'd0, 1'b0);
    run_pick(2'd1, 1'b0);
    run_pick(2'd2, 1'b0);
    voq_empty  = 4'b1001;
    voq_picked = 4'b0010;
    run_pick(2'd2, 1'b0);
    voq_empty  = 4'b0000;
    voq_picked = 4'b0000;
    run_pick(2'd3, 1'b0);
  endtask

  task automatic test_none();
    apply_reset();
    run_pick(2'd0, 1'b0);
    voq_empty = 4'b1111;
    run_pick(2'd1, 1'b1);
    voq_empty  = 4'b0000;
    voq_picked = 4'b1111;
    run_pick(2'd1, 1'b1);
    voq_picked = 4'b0000;
    run_pick(2'd1, 1'b0);
  endtask

  task automatic test_prio();
    apply_reset();
    policy       = 1'b1;
    prio_wr_data = {2'd2, 2'd0, 2'd1, 2'd3};
    prio_wr_en   = 1'b1;
    @(posedge clk); #1;
    prio_wr_en = 1'b0;
    pick_ready = 1'b0;
    sb_q.push_back(3'b0_11);
    pick_req = 1'b1;
    @(posedge clk); #1;
    pick_req = 1'b0;
    @(posedge clk); #1;
    prio_wr_data = {2'd3, 2'd2, 2'd1, 2'd0};
    prio_wr_en   = 1'b1;
    @(negedge clk);
    checks++; if (voq_to_pick !== 2'd3) begin failures++; $display("FAIL prio_offer: got %0d want 3", voq_to_pick); end
    @(posedge clk); #1;
    prio_wr_en = 1'b0;
    pick_ready = 1'b1;
    wait_hs();
    voq_picked = 4'b1000;
    run_pick(2'd1, 1'b0);
    // Same-cycle write and request: this pick sees the reset (identity) table.
    apply_reset();
    policy       = 1'b1;
    prio_wr_data = {2'd2, 2'd0, 2'd1, 2'd3};
    sb_q.push_back(3'b0_00);
    prio_wr_en = 1'b1;
    pick_req   = 1'b1;
    @(posedge clk); #1;
    prio_wr_en = 1'b0;
    pick_req   = 1'b0;
    wait_hs();
    run_pick(2'd3, 1'b0);
  endtask

  task automatic test_starve();
    apply_reset();
    policy    = 1'b1;
    voq_empty = 4'b1100;
    run_pick(2'd0, 1'b0);
    run_pick(2'd0, 1'b0);
    run_pick(2'd1, 1'b0);
    run_pick(2'd0, 1'b0);
    run_pick(2'd0, 1'b0);
    run_pick(2'd1, 1'b0);
  endtask

  task automatic test_stall();
    apply_reset();
    pick_ready = 1'b0;
    sb_q.push_back(3'b0_00);
    pick_req = 1'b1;
    @(posedge clk); #1;
    pick_req = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      voq_empty  = 4'($urandom);
      voq_picked = 4'($urandom);
      policy     = 1'($urandom);
      pick_req   = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({pick_valid, no_available_voq, voq_to_pick} !== 4'b1_0_00) begin
        failures++;
        $display("FAIL stall_hold: cycle %0d got valid=%0b none=%0b voq=%0d want 1 0 0",
                 c, pick_valid, no_available_voq, voq_to_pick);
      end
      @(posedge clk); #1;
    end
    drive_defaults();
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (pick_valid !== 1'b0) begin failures++; $display("FAIL stall_idle: got valid=%0b want 0", pick_valid); end
    @(posedge clk); #1;
    run_pick(2'd1, 1'b0);
  endtask

  task automatic test_reset_offer();
    apply_reset();
    run_pick(2'd0, 1'b0);
    pick_ready = 1'b0;
    sb_q.push_back(3'b0_01);
    pick_req = 1'b1;
    @(posedge clk); #1;
    pick_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({pick_valid, voq_to_pick} !== 3'b1_01) begin
      failures++;
      $display("FAIL offer_pre_rst: got valid=%0b voq=%0d want 1 1", pick_valid, voq_to_pick);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (pick_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid: got %0b want 0", pick_valid); end
    checks++; if (voq_to_pick !== 2'd0) begin failures++; $display("FAIL async_rst_voq: got %0d want 0", voq_to_pick); end
    checks++; if (no_available_voq !== 1'b0) begin failures++; $display("FAIL async_rst_none: got %0b want 0", no_available_voq); end
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    reset_n    = 1'b1;
    pick_ready = 1'b1;
    @(posedge clk); #1;
    run_pick(2'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n_valid;
    apply_reset();
    n_valid = 0;
    for (int k = 0; k < 4; k++) sb_q.push_back({1'b0, 2'(k)});
    pick_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (pick_valid) n_valid++;
    end
    @(posedge clk); #1;
    pick_req = 1'b0;
    checks++; if (n_valid !== 4) begin failures++; $display("FAIL b2b_count: got %0d offers in 12 cycles want 4", n_valid); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_rr();
    test_rr_wrap();
    test_none();
    test_prio();
    test_starve();
    test_stall();
    test_reset_offer();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending expectations want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
